// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: measures line/frame timing, locks, recovers pixel position.
// Optional macro VGA_DEC_SYNC_EN adds a two-flop input synchronizer for asynchronous sources.
module vga_sync_decoder #(
  parameter int H_VISIBLE   = 640,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_BACK      = 32,
  parameter int CNT_W       = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             active,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked,
  output logic             err
);

  localparam int MW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAXV   = '1;
  localparam logic [CNT_W-1:0] MAXM1  = MAXV - ONE;
  localparam logic [CNT_W-1:0] HB     = CNT_W'(H_BACK);
  localparam logic [CNT_W-1:0] HE     = CNT_W'(H_BACK + H_VISIBLE);
  localparam logic [CNT_W-1:0] VB     = CNT_W'(V_BACK);
  localparam logic [CNT_W-1:0] VE     = CNT_W'(V_BACK + V_VISIBLE);
  localparam logic [MW-1:0]    LOCKN  = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  logic hsSmp, vsSmp;

`ifdef VGA_DEC_SYNC_EN
  logic [1:0] hsSync_q, vsSync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsSync_q <= 2'b11;
      vsSync_q <= 2'b11;
    end else begin
      hsSync_q <= {hsSync_q[0], hsync_in};
      vsSync_q <= {vsSync_q[0], vsync_in};
    end
  end

  assign hsSmp = hsSync_q[1];
  assign vsSmp = vsSync_q[1];
`else
  assign hsSmp = hsync_in;
  assign vsSmp = vsync_in;
`endif

  logic             hsPrev_q, vsPrev_q;
  logic [CNT_W-1:0] hPos_q, hPos_d, vLine_q, vLine_d;
  logic [CNT_W-1:0] lineLen_q, lineLen_d, frameLines_q, frameLines_d;
  logic [CNT_W-1:0] refLen_q, refLen_d, refLines_q, refLines_d;
  logic             hArmed_q, hArmed_d, vArmed_q, vArmed_d;
  logic             refValid_q, refValid_d, dirty_q, dirty_d;
  logic [MW-1:0]    matchCnt_q, matchCnt_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] pixelX_q, pixelY_q;
  logic             active_q, locked_q, err_q, err_d;

  logic             hRise, vRise, timeout, lineChanged, lineMatch, frameMatch;
  logic [CNT_W-1:0] lineCount;

  assign hRise = hsSmp & ~hsPrev_q;
  assign vRise = vsSmp & ~vsPrev_q;

  // Counters and measurements; a simultaneous hsync rise still belongs to the closing frame.
  always_comb begin
    timeout      = ~hRise && (hPos_q == MAXM1);
    hPos_d       = hRise ? '0 : ((hPos_q == MAXV) ? MAXV : hPos_q + ONE);
    lineLen_d    = lineLen_q;
    hArmed_d     = hArmed_q;
    if (hRise) begin
      if (hArmed_q) lineLen_d = hPos_q + ONE;
      hArmed_d = 1'b1;
    end
    lineChanged  = hRise && hArmed_q && (lineLen_d != lineLen_q);
    lineCount    = (hRise && (vLine_q != MAXV)) ? vLine_q + ONE : vLine_q;
    vLine_d      = vRise ? '0 : lineCount;
    frameLines_d = frameLines_q;
    vArmed_d     = vArmed_q;
    if (vRise) begin
      if (vArmed_q) frameLines_d = lineCount;
      vArmed_d = 1'b1;
    end
    lineMatch  = (lineLen_d == refLen_q);
    frameMatch = (frameLines_d == refLines_q);
  end

  // Lock FSM; a frame touched by a line-length change is discarded as a reference.
  always_comb begin
    state_d    = state_q;
    matchCnt_d = matchCnt_q;
    refLen_d   = refLen_q;
    refLines_d = refLines_q;
    refValid_d = refValid_q;
    dirty_d    = dirty_q;
    err_d      = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (vRise) begin
          state_d    = ACQUIRE;
          matchCnt_d = '0;
          refLen_d   = '0;
          refLines_d = '0;
          refValid_d = 1'b0;
          dirty_d    = 1'b0;
        end
      end
      ACQUIRE: begin
        if (lineChanged) begin
          matchCnt_d = '0;
          dirty_d    = 1'b1;
        end
        if (vRise) begin
          dirty_d = 1'b0;
          if (dirty_q || lineChanged || !vArmed_q) begin
            matchCnt_d = '0;
            refValid_d = 1'b0;
          end else begin
            refLen_d   = lineLen_d;
            refLines_d = frameLines_d;
            refValid_d = 1'b1;
            if (!refValid_q)                matchCnt_d = MW'(1);
            else if (lineMatch && frameMatch) matchCnt_d = matchCnt_q + MW'(1);
            else                            matchCnt_d = '0;
            if (matchCnt_d == LOCKN) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if ((vRise && !frameMatch) || (hRise && !lineMatch)) begin
          err_d      = 1'b1;
          state_d    = ACQUIRE;
          matchCnt_d = '0;
          refValid_d = 1'b0;
          dirty_d    = ~vRise;
        end
      end
      default: state_d = UNLOCKED;
    endcase
    if (timeout) begin
      err_d      = (state_q == LOCKED);
      state_d    = UNLOCKED;
      matchCnt_d = '0;
      refValid_d = 1'b0;
      dirty_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsPrev_q     <= 1'b1;
      vsPrev_q     <= 1'b1;
      hPos_q       <= '0;
      vLine_q      <= '0;
      lineLen_q    <= '0;
      frameLines_q <= '0;
      refLen_q     <= '0;
      refLines_q   <= '0;
      hArmed_q     <= 1'b0;
      vArmed_q     <= 1'b0;
      refValid_q   <= 1'b0;
      dirty_q      <= 1'b0;
      matchCnt_q   <= '0;
      state_q      <= UNLOCKED;
      pixelX_q     <= '0;
      pixelY_q     <= '0;
      active_q     <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      hsPrev_q     <= hsSmp;
      vsPrev_q     <= vsSmp;
      hPos_q       <= hPos_d;
      vLine_q      <= vLine_d;
      lineLen_q    <= lineLen_d;
      frameLines_q <= frameLines_d;
      refLen_q     <= refLen_d;
      refLines_q   <= refLines_d;
      hArmed_q     <= hArmed_d && !timeout;
      vArmed_q     <= vArmed_d && !timeout;
      refValid_q   <= refValid_d;
      dirty_q      <= dirty_d;
      matchCnt_q   <= matchCnt_d;
      state_q      <= state_d;
      pixelX_q     <= hPos_d - HB;
      pixelY_q     <= vLine_d - VB;
      active_q     <= (state_d == LOCKED) && (hPos_d >= HB) && (hPos_d < HE) &&
                      (vLine_d >= VB) && (vLine_d < VE);
      locked_q     <= (state_d == LOCKED);
      err_q        <= err_d;
    end
  end

  assign pixel_x     = pixelX_q;
  assign pixel_y     = pixelY_q;
  assign active      = active_q;
  assign line_len    = lineLen_q;
  assign frame_lines = frameLines_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder driven by a small-format sync generator (40x20 clocks).
module tb_vga_sync_decoder;

  localparam int CNT_W = 11;
  localparam int HT = 40, HS = 4, HBK = 4, HV = 24;
  localparam int VT = 20, VBK = 3, VV = 10;
  localparam int VRISE = 2 * HT + HS;
`ifdef VGA_DEC_SYNC_EN
  localparam int LAG = 3;
`else
  localparam int LAG = 1;
`endif

  logic             clk = 1'b0;
  logic             rst, hsync_in, vsync_in;
  logic [CNT_W-1:0] pixel_x, pixel_y, line_len, frame_lines;
  logic             active, locked, err;

  int assertCount = 0;
  int failCount   = 0;
  int genFrame    = 0;
  int genP        = 0;
  int suppressFrame = -1;
  bit forceHigh   = 1'b0;
  bit rstReq      = 1'b0;
  int errHigh     = 0;
  int errRises    = 0;
  bit errPrev     = 1'b0;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_BACK(HBK), .V_VISIBLE(VV), .V_BACK(VBK),
    .CNT_W(CNT_W), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .active(active),
    .line_len(line_len), .frame_lines(frame_lines), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err) errHigh++;
    if (err && !errPrev) errRises++;
    errPrev = err;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // One clock: drive the generator position (or overrides), then step the generator.
  task automatic applyStimulus();
    int hc, vc;
    hc = genP % HT;
    vc = genP / HT;
    if (forceHigh) begin
      hsync_in = 1'b1;
      vsync_in = 1'b1;
    end else begin
      hsync_in = (hc >= HS) || (genFrame == suppressFrame && vc == 10);
      vsync_in = !(genP >= HS && genP < VRISE);
    end
    rst = rstReq;
    @(posedge clk);
    @(negedge clk);
    if (!forceHigh) begin
      genP++;
      if (genP == HT * VT) begin
        genP = 0;
        genFrame++;
      end
    end
  endtask

  task automatic runTo(input int f, input int p);
    int guard;
    guard = 0;
    while (!(genFrame == f && genP == p) && guard < 60000) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 60000) checkOutput("runTo bound", 0, 1);
    applyStimulus();
  endtask

  task automatic at(input int f, input int vc, input int hc);
    runTo(f, vc * HT + hc + LAG - 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " pixel_x"}, 32'(pixel_x), 0);
    checkOutput({tag, " pixel_y"}, 32'(pixel_y), 0);
    checkOutput({tag, " line_len"}, 32'(line_len), 0);
    checkOutput({tag, " frame_lines"}, 32'(frame_lines), 0);
    checkOutput({tag, " active"}, 32'(active), 0);
    checkOutput({tag, " locked"}, 32'(locked), 0);
    checkOutput({tag, " err"}, 32'(err), 0);
  endtask

  initial begin
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    at(0, 1, 3);  checkOutput("line_len armed only", 32'(line_len), 0);
    at(0, 1, 4);  checkOutput("line_len first", 32'(line_len), HT);
    at(0, 2, 4);  checkOutput("frame_lines armed only", 32'(frame_lines), 0);
    checkOutput("locked after rise1", 32'(locked), 0);
    at(1, 2, 4);  checkOutput("frame_lines rise2", 32'(frame_lines), VT);
    checkOutput("locked after rise2", 32'(locked), 0);
    at(2, 2, 3);  checkOutput("locked before rise3", 32'(locked), 0);
    checkOutput("pixel_y before vsync", 32'(pixel_y), 16);
    at(2, 2, 4);  checkOutput("locked at rise3", 32'(locked), 1);
    checkOutput("pixel_y vsync wins", 32'(pixel_y), 2045);
    checkOutput("frame_lines simultaneous", 32'(frame_lines), VT);

    at(3, 4, 8);  checkOutput("row above visible active", 32'(active), 0);
    checkOutput("row above pixel_y", 32'(pixel_y), 2047);
    at(3, 5, 7);  checkOutput("col before visible active", 32'(active), 0);
    checkOutput("col before pixel_x", 32'(pixel_x), 2047);
    at(3, 5, 8);  checkOutput("first pixel active", 32'(active), 1);
    checkOutput("first pixel x", 32'(pixel_x), 0);
    checkOutput("first pixel y", 32'(pixel_y), 0);
    at(3, 14, 31); checkOutput("last pixel active", 32'(active), 1);
    checkOutput("last pixel x", 32'(pixel_x), HV - 1);
    checkOutput("last pixel y", 32'(pixel_y), VV - 1);
    at(3, 14, 32); checkOutput("past last col active", 32'(active), 0);
    checkOutput("past last col x", 32'(pixel_x), HV);
    at(3, 15, 8); checkOutput("past last row active", 32'(active), 0);
    checkOutput("past last row y", 32'(pixel_y), VV);

    suppressFrame = 4;
    at(4, 11, 4); checkOutput("missing hsync line_len", 32'(line_len), 2 * HT);
    checkOutput("missing hsync err", 32'(err), 1);
    checkOutput("missing hsync locked", 32'(locked), 0);
    at(4, 11, 5); checkOutput("err one cycle", 32'(err), 0);
    at(4, 12, 4); checkOutput("line_len recovers", 32'(line_len), HT);
    at(5, 2, 4);  checkOutput("short frame_lines", 32'(frame_lines), VT - 1);
    checkOutput("locked dirty frame", 32'(locked), 0);
    at(6, 2, 4);  checkOutput("locked clean1", 32'(locked), 0);
    at(7, 2, 3);  checkOutput("locked before clean2", 32'(locked), 0);
    at(7, 2, 4);  checkOutput("relock clean2", 32'(locked), 1);
    checkOutput("err count relock", 32'(errRises), 1);

    runTo(8, 10 * HT + 19);
    checkOutput("locked before hold", 32'(locked), 1);
    forceHigh = 1'b1;
    repeat (2100) applyStimulus();
    forceHigh = 1'b0;
    checkOutput("timeout locked", 32'(locked), 0);
    checkOutput("timeout active", 32'(active), 0);
    checkOutput("timeout err count", 32'(errRises), 2);
    genFrame = 9; genP = 0;
    at(10, 2, 4); checkOutput("restart locked rise2", 32'(locked), 0);
    checkOutput("restart frame_lines", 32'(frame_lines), VT);
    at(11, 2, 3); checkOutput("restart locked before rise3", 32'(locked), 0);
    at(11, 2, 4); checkOutput("restart locked rise3", 32'(locked), 1);

    runTo(12, 10 * HT + 19);
    rstReq = 1'b1;
    applyStimulus();
    rstReq = 1'b0;
    checkAllZero("mid reset");
    applyStimulus();
    checkOutput("mid reset err after", 32'(err), 0);
    checkOutput("mid reset line_len after", 32'(line_len), 0);
    at(14, 2, 4); checkOutput("post reset locked rise2", 32'(locked), 0);
    at(15, 2, 3); checkOutput("post reset before rise3", 32'(locked), 0);
    at(15, 2, 4); checkOutput("post reset locked rise3", 32'(locked), 1);
    checkOutput("post reset line_len", 32'(line_len), HT);
    checkOutput("post reset frame_lines", 32'(frame_lines), VT);
    applyStimulus();
    applyStimulus();
    checkOutput("total err pulses", 32'(errRises), 2);
    checkOutput("err pulse width", 32'(errHigh), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
